mem_bus_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the CPU's single shared memory port.
- Port 0 is instruction fetch; port 1 is data load/store.
- Grants one requester at a time, drives the memory address/data/write lines for a fixed-latency access, captures read data and error, and returns a one-cycle done pulse to the winner.
- Sits between the CPU fetch/memory-stage sequencers and the memory model.

---
 rtl/mem_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port fixed-latency arbiter/sequencer for the CPU's shared memory port.
// Optional build macro ARB_DATA_PRIORITY_EN: port 1 (data) always wins a tie.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_write,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_error,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_write,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_error,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_error,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            state, state_d;
  logic              last_grant;
  logic              winner;
  logic              any_req;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_write;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    any_req = m0_req | m1_req;
    winner  = m1_req;
    if (m0_req && m1_req) begin
`ifdef ARB_DATA_PRIORITY_EN
      winner = 1'b1;
`else
      winner = ~last_grant;
`endif
    end
    case (state)
      IDLE:    if (any_req) state_d = WAIT;
      WAIT:    if (cnt == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: datapath registers are reset too, because the all-zero output
  // state after reset depends on them (grant_id, response data).
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      cnt        <= 4'd0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_id   <= winner;
          last_grant <= winner;
          cnt        <= CNT_INIT;
          lat_addr   <= winner ? m1_addr  : m0_addr;
          lat_wdata  <= winner ? m1_wdata : m0_wdata;
          lat_write  <= winner ? m1_write : m0_write;
        end
        WAIT: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          resp_rdata <= lat_write ? '0 : mem_rdata;
          resp_error <= mem_error;
        end
        default: ;
      endcase
    end
  end

  // Memory-side lines are forced to zero outside WAIT.
  assign mem_valid = (state == WAIT);
  assign mem_addr  = mem_valid ? lat_addr  : '0;
  assign mem_wdata = mem_valid ? lat_wdata : '0;
  assign mem_write = mem_valid & lat_write;
  assign busy      = (state != IDLE);

  assign m0_done  = (state == RESP) && !grant_id;
  assign m1_done  = (state == RESP) &&  grant_id;
  assign m0_rdata = m0_done ? resp_rdata : '0;
  assign m1_rdata = m1_done ? resp_rdata : '0;
  assign m0_error = m0_done & resp_error;
  assign m1_error = m1_done & resp_error;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (MEM_LATENCY=2).
module tb_mem_bus_arbiter;

  localparam int L = 2;
`ifdef ARB_DATA_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_done, m0_error, m1_done, m1_error;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid, mem_write, busy, grant_id;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_error = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_error(m0_error),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_error(m1_error),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input logic req, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic wr);
    if (port) begin
      m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_write = wr;
    end else begin
      m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_write = wr;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".mem_valid"}, 32'(mem_valid), 32'd0);
    check({tag, ".mem_addr"},  mem_addr, 32'd0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    check({tag, ".mem_write"}, 32'(mem_write), 32'd0);
    check({tag, ".m0_done"},   32'(m0_done), 32'd0);
    check({tag, ".m1_done"},   32'(m1_done), 32'd0);
    check({tag, ".m0_rdata"},  m0_rdata, 32'd0);
    check({tag, ".m1_rdata"},  m1_rdata, 32'd0);
    check({tag, ".m0_error"},  32'(m0_error), 32'd0);
    check({tag, ".m1_error"},  32'(m1_error), 32'd0);
    check({tag, ".busy"},      32'(busy), 32'd0);
  endtask

  // Checks the WAIT cycles; memory returns rd/err only in the last one.
  task automatic check_wait(input string tag, input bit port, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic wr,
                            input logic [31:0] rd, input logic err);
    for (int i = 0; i < L; i++) begin
      check({tag, ".mem_valid"}, 32'(mem_valid), 32'd1);
      check({tag, ".mem_addr"},  mem_addr, addr);
      check({tag, ".mem_wdata"}, mem_wdata, wdata);
      check({tag, ".mem_write"}, 32'(mem_write), 32'(wr));
      check({tag, ".grant_id"},  32'(grant_id), 32'(port));
      check({tag, ".busy"},      32'(busy), 32'd1);
      if (i == L - 1) begin
        mem_rdata = rd;
        mem_error = err;
      end
      tick();
    end
    mem_rdata = 32'h0BAD_0BAD;
    mem_error = 1'b0;
  endtask

  task automatic check_resp(input string tag, input bit port, input logic [31:0] rd,
                            input logic err);
    check({tag, ".done"},      32'(port ? m1_done : m0_done), 32'd1);
    check({tag, ".other_done"},32'(port ? m0_done : m1_done), 32'd0);
    check({tag, ".rdata"},     port ? m1_rdata : m0_rdata, rd);
    check({tag, ".error"},     32'(port ? m1_error : m0_error), 32'(err));
    check({tag, ".mem_valid"}, 32'(mem_valid), 32'd0);
    check({tag, ".mem_addr"},  mem_addr, 32'd0);
    check({tag, ".busy"},      32'(busy), 32'd1);
    check({tag, ".grant_id"},  32'(grant_id), 32'(port));
  endtask

  task automatic run_txn(input string tag, input bit port, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic wr,
                         input logic [31:0] rd, input logic err);
    set_req(port, 1'b1, addr, wdata, wr);
    tick();
    check_wait(tag, port, addr, wdata, wr, rd, err);
    check_resp(tag, port, wr ? 32'd0 : rd, err);
    set_req(port, 1'b0, '0, '0, 1'b0);
    tick();
    check_idle({tag, ".after"});
    check({tag, ".grant_hold"}, 32'(grant_id), 32'(port));
  endtask

  initial begin
    logic exp_port;

    // Reset state
    tick(); tick();
    check_idle("reset");
    check("reset.grant_id", 32'(grant_id), 32'd0);
    rst = 1'b0;
    tick();
    check_idle("idle_no_req");

    // Port 0 read and port 1 write
    run_txn("p0_read", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hE3A0_1005, 1'b0);
    run_txn("p1_write", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'h5555_AAAA, 1'b0);

    // Both requesting continuously from reset: round-robin or data priority
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(1'b0, 1'b1, 32'h0000_1000, 32'h0, 1'b0);
    set_req(1'b1, 1'b1, 32'h0000_2000, 32'h0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      exp_port = PRIO ? 1'b1 : n[0];
      tick();
      check("both.grant_id", 32'(grant_id), 32'(exp_port));
      check("both.mem_addr", mem_addr, exp_port ? 32'h0000_2000 : 32'h0000_1000);
      for (int i = 1; i < L; i++) tick();
      mem_rdata = 32'h100 + 32'(n);
      tick();
      check_resp("both", exp_port, 32'h100 + 32'(n), 1'b0);
      tick();
      check("both.idle_busy", 32'(busy), 32'd0);
    end
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    tick();
    check_idle("both.done");

    // Error reported once, cleared on the next transaction
    run_txn("p0_err", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1234_5678, 1'b1);
    run_txn("p0_noerr", 1'b0, 32'h0000_0024, 32'h0, 1'b0, 32'h9ABC_DEF0, 1'b0);

    // Reset in the second WAIT cycle of a port 1 read
    set_req(1'b1, 1'b1, 32'h0000_0300, 32'h0, 1'b0);
    tick();
    check("rst_mid.grant", 32'(grant_id), 32'd1);
    tick();
    check("rst_mid.valid", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    mem_rdata = 32'hFFFF_FFFF;
    mem_error = 1'b1;
    tick();
    rst = 1'b0;
    mem_error = 1'b0;
    check_idle("rst_mid");
    check("rst_mid.grant_id", 32'(grant_id), 32'd0);
    set_req(1'b0, 1'b1, 32'h0000_0400, 32'h0, 1'b0);
    set_req(1'b1, 1'b1, 32'h0000_0500, 32'h0, 1'b0);
    tick();
    exp_port = PRIO ? 1'b1 : 1'b0;
    check("rst_tie.grant_id", 32'(grant_id), 32'(exp_port));
    check("rst_tie.mem_addr", mem_addr, exp_port ? 32'h0000_0500 : 32'h0000_0400);
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < L; i++) tick();
    check("rst_tie.done", 32'(exp_port ? m1_done : m0_done), 32'd1);
    tick();
    check_idle("rst_tie.after");

    // Port 1 drops req mid-WAIT; port 0 request arriving in WAIT waits for IDLE
    set_req(1'b1, 1'b1, 32'h0000_0600, 32'h0, 1'b0);
    tick();
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    set_req(1'b0, 1'b1, 32'h0000_0700, 32'hCAFE_F00D, 1'b1);
    check_wait("drop", 1'b1, 32'h0000_0600, 32'h0, 1'b0, 32'h7777_0001, 1'b0);
    check_resp("drop", 1'b1, 32'h7777_0001, 1'b0);
    tick();
    check("late.idle_busy", 32'(busy), 32'd0);
    check("late.idle_valid", 32'(mem_valid), 32'd0);
    tick();
    check_wait("late", 1'b0, 32'h0000_0700, 32'hCAFE_F00D, 1'b1, 32'h7777_0002, 1'b0);
    check_resp("late", 1'b0, 32'd0, 1'b0);
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    check_idle("late.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
